// File: rtl/hpdmc_busmaster.sv
// hpdmc_busmaster: streaming client to 4-beat WISHBONE bursts on the HPDMC port.
// Define HPDMC_NEXTADR_EN to drive next-burst address prediction during reads.

module hpdmc_busmaster #(
    parameter int rfifo_depth = 8,
    parameter int wfifo_depth = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [15:0] cmd_len,
    input  logic        wdat_valid,
    output logic        wdat_ready,
    input  logic [63:0] wdat,
    input  logic [7:0]  wsel,
    output logic        rdat_valid,
    input  logic        rdat_ready,
    output logic [63:0] rdat,
    output logic        busy,
    output logic        done,
    output logic [31:0] wb_adr_o,
    output logic [2:0]  wb_cti_o,
    output logic [63:0] wb_dat_o,
    output logic [7:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic [63:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        wb_nextadr_valid,
    output logic [31:0] wb_nextadr
);

    localparam int RAW = $clog2(rfifo_depth);
    localparam int WAW = $clog2(wfifo_depth);
    localparam logic [RAW-1:0] RP1 = {{(RAW-1){1'b0}}, 1'b1};
    localparam logic [RAW:0]   RC1 = {{RAW{1'b0}}, 1'b1};
    localparam logic [WAW-1:0] WP1 = {{(WAW-1){1'b0}}, 1'b1};
    localparam logic [WAW:0]   WC1 = {{WAW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        r_we;
    logic [31:0] r_adr;
    logic [15:0] r_cnt;
    logic [1:0]  r_beat;

    logic w_ack;
    logic w_accept;
    logic w_unused;

    logic [63:0]    r_rf_mem [rfifo_depth];
    logic [RAW-1:0] r_rf_wp;
    logic [RAW-1:0] r_rf_rp;
    logic [RAW:0]   r_rf_cnt;
    logic           w_rf_push;
    logic           w_rf_pop;
    logic           w_rf_room;

    logic [63:0]    r_wf_dat [wfifo_depth];
    logic [7:0]     r_wf_sel [wfifo_depth];
    logic [WAW-1:0] r_wf_wp;
    logic [WAW-1:0] r_wf_rp;
    logic [WAW:0]   r_wf_cnt;
    logic           w_wf_push;
    logic           w_wf_pop;
    logic           w_wf_have;
    logic           w_wf_empty;

    assign w_unused = ^cmd_adr[4:0];

    // Acks only count while a beat is actually being strobed.
    assign w_ack    = wb_ack_i & (r_state == S_BURST);
    assign w_accept = cmd_valid & (r_state == S_IDLE);

    assign w_rf_push = w_ack & ~r_we;
    assign w_rf_pop  = rdat_valid & rdat_ready;
    assign w_rf_room = int'(r_rf_cnt) <= (rfifo_depth - 4);
    assign rdat_valid = (r_rf_cnt != '0);
    assign rdat       = r_rf_mem[r_rf_rp];

    assign w_wf_empty = (r_wf_cnt == '0);
    assign wdat_ready = int'(r_wf_cnt) != wfifo_depth;
    assign w_wf_push  = wdat_valid & wdat_ready;
    assign w_wf_pop   = w_ack & r_we;
    assign w_wf_have  = int'(r_wf_cnt) >= 4;
    assign wb_dat_o   = w_wf_empty ? 64'd0 : r_wf_dat[r_wf_rp];
    assign wb_sel_o   = w_wf_empty ? 8'd0 : r_wf_sel[r_wf_rp];

    assign wb_adr_o = r_adr;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_cti_o  = 3'b000;
        unique case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = (cmd_len == 16'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_we ? w_wf_have : w_rf_room) begin
                    w_next = S_BURST;
                end
            end
            S_BURST: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = r_we;
                wb_cti_o = (r_beat == 2'd3) ? 3'b111 : 3'b010;
                if (w_ack && r_beat == 2'd3) begin
                    w_next = (r_cnt == 16'd1) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                w_next = S_WAIT;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_we   <= 1'b0;
            r_adr  <= 32'd0;
            r_cnt  <= 16'd0;
            r_beat <= 2'd0;
        end else begin
            if (w_accept) begin
                r_we   <= cmd_we;
                r_adr  <= {cmd_adr[31:5], 5'b0};
                r_cnt  <= cmd_len;
                r_beat <= 2'd0;
            end
            if (w_ack) begin
                r_adr  <= r_adr + 32'd8;
                r_beat <= r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    r_cnt <= r_cnt - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_rf_push) begin
            r_rf_mem[r_rf_wp] <= wb_dat_i;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rf_wp  <= '0;
            r_rf_rp  <= '0;
            r_rf_cnt <= '0;
        end else begin
            if (w_rf_push) begin
                r_rf_wp <= r_rf_wp + RP1;
            end
            if (w_rf_pop) begin
                r_rf_rp <= r_rf_rp + RP1;
            end
            case ({w_rf_push, w_rf_pop})
                2'b10:   r_rf_cnt <= r_rf_cnt + RC1;
                2'b01:   r_rf_cnt <= r_rf_cnt - RC1;
                default: r_rf_cnt <= r_rf_cnt;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wf_push) begin
            r_wf_dat[r_wf_wp] <= wdat;
            r_wf_sel[r_wf_wp] <= wsel;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_wf_wp  <= '0;
            r_wf_rp  <= '0;
            r_wf_cnt <= '0;
        end else begin
            if (w_wf_push) begin
                r_wf_wp <= r_wf_wp + WP1;
            end
            if (w_wf_pop) begin
                r_wf_rp <= r_wf_rp + WP1;
            end
            case ({w_wf_push, w_wf_pop})
                2'b10:   r_wf_cnt <= r_wf_cnt + WC1;
                2'b01:   r_wf_cnt <= r_wf_cnt - WC1;
                default: r_wf_cnt <= r_wf_cnt;
            endcase
        end
    end

`ifdef HPDMC_NEXTADR_EN
    logic w_pred;
    // Bursts are 32-byte aligned, so the upper address bits name the burst.
    assign w_pred = ~r_we & ((r_state == S_WAIT) | (r_state == S_BURST));
    assign wb_nextadr = w_pred ? {r_adr[31:5] + 27'd1, 5'b0} : 32'd0;
    assign wb_nextadr_valid = w_pred & (r_cnt > 16'd1);
`else
    assign wb_nextadr = 32'd0;
    assign wb_nextadr_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hpdmc_busmaster.sv
// tb_hpdmc_busmaster: command table plus scoreboard of expected beats and read words.
// Covers bursts, wrap, backpressure, zero length and reset mid-burst.

module tb_hpdmc_busmaster;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [15:0] cmd_len = 16'd0;
    logic        wdat_valid = 1'b0;
    logic        wdat_ready;
    logic [63:0] wdat = 64'd0;
    logic [7:0]  wsel = 8'd0;
    logic        rdat_valid;
    logic        rdat_ready = 1'b1;
    logic [63:0] rdat;
    logic        busy;
    logic        done;
    logic [31:0] wb_adr_o;
    logic [2:0]  wb_cti_o;
    logic [63:0] wb_dat_o;
    logic [7:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [63:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_nextadr_valid;
    logic [31:0] wb_nextadr;

    bit ack_en = 1'b1;
    bit stall_mode = 1'b0;
    bit spur = 1'b0;

    always #5 sys_clk = ~sys_clk;

    hpdmc_busmaster dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_adr(cmd_adr),
        .cmd_len(cmd_len),
        .wdat_valid(wdat_valid),
        .wdat_ready(wdat_ready),
        .wdat(wdat),
        .wsel(wsel),
        .rdat_valid(rdat_valid),
        .rdat_ready(rdat_ready),
        .rdat(rdat),
        .busy(busy),
        .done(done),
        .wb_adr_o(wb_adr_o),
        .wb_cti_o(wb_cti_o),
        .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .wb_nextadr_valid(wb_nextadr_valid),
        .wb_nextadr(wb_nextadr)
    );

    function automatic logic [63:0] mem_fn(input logic [31:0] a);
        return {~a, a ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [63:0] wword(input int i);
        return {32'hD00D_0000 + 32'(i), 32'(i * 7 + 3)};
    endfunction

    function automatic logic [7:0] wsel_fn(input int i);
        return 8'(i * 37 + 1);
    endfunction

    // Slave: data is a function of the address; ack optionally stalls or fires spuriously.
    assign wb_dat_i = mem_fn(wb_adr_o);
    assign wb_ack_i = ack_en & (wb_stb_o | spur);

    always @(posedge sys_clk) begin
        ack_en <= stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [63:0] dat;
        logic [7:0]  sel;
        logic        nv;
        logic [31:0] na;
    } beat_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [15:0] len;
        logic [31:0] base;
        bit          stall;
        bit          spur;
    } vec_t;

    beat_t       beat_q[$];
    logic [63:0] rdat_q[$];
    beat_t       mon_e;

    int errors = 0;
    int checks = 0;
    int beat_cnt = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int cyc_cnt = 0;
    int low_run = 0;
    int cmd_beat0 = 0;
    bit gap_en = 1'b0;
    bit prev_stb = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (wb_cyc_o) cyc_cnt++;
            if (done) done_cnt++;
            if (gap_en && wb_stb_o && !prev_stb && beat_cnt > cmd_beat0)
                chk("burst_gap", 64'(low_run), 64'd2);
            if (wb_stb_o) low_run = 0;
            else low_run++;
            if (wb_stb_o && wb_ack_i) begin
                beat_cnt++;
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: adr %0h, none expected",
                             wb_adr_o);
                end else begin
                    mon_e = beat_q.pop_front();
                    chk("beat_adr", 64'(wb_adr_o), 64'(mon_e.adr));
                    chk("beat_cti", 64'(wb_cti_o), 64'(mon_e.cti));
                    chk("beat_we", 64'(wb_we_o), 64'(mon_e.we));
                    if (mon_e.we) begin
                        chk("beat_dat", wb_dat_o, mon_e.dat);
                        chk("beat_sel", 64'(wb_sel_o), 64'(mon_e.sel));
                    end
                    chk("nextadr_valid", 64'(wb_nextadr_valid), 64'(mon_e.nv));
                    chk("nextadr", 64'(wb_nextadr), 64'(mon_e.na));
                end
            end
            if (rdat_valid && rdat_ready) begin
                pop_cnt++;
                if (rdat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdat: got %0h, none expected", rdat);
                end else begin
                    chk("rdat", rdat, rdat_q.pop_front());
                end
            end
        end
        prev_stb = wb_stb_o;
    end

    task automatic push_exp(input logic we, input logic [31:0] base,
                            input int len, input int widx);
        beat_t e;
        for (int b = 0; b < len; b++) begin
            for (int k = 0; k < 4; k++) begin
                e.adr = base + 32'(32 * b + 8 * k);
                e.cti = (k == 3) ? 3'b111 : 3'b010;
                e.we  = we;
                e.dat = wword(widx + 4 * b + k);
                e.sel = wsel_fn(widx + 4 * b + k);
`ifdef HPDMC_NEXTADR_EN
                e.nv = !we && (len - b > 1);
                e.na = we ? 32'd0 : base + 32'(32 * (b + 1));
`else
                e.nv = 1'b0;
                e.na = 32'd0;
`endif
                if (!we) rdat_q.push_back(mem_fn(e.adr));
                beat_q.push_back(e);
            end
        end
    endtask

    task automatic preload(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            wdat = wword(idx + i);
            wsel = wsel_fn(idx + i);
            wdat_valid = 1'b1;
            chk("wdat_ready_preload", 64'(wdat_ready), 64'd1);
            @(posedge sys_clk);
            #1;
        end
        wdat_valid = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr,
                         input logic [15:0] len);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_we = we;
        cmd_adr = adr;
        cmd_len = len;
        cmd_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int done_c, output int stb_c);
        done_c = 0;
        stb_c = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge sys_clk);
            if (wb_stb_o && stb_c == 0) stb_c = c;
            if (done) begin
                done_c = c;
                break;
            end
        end
        checks++;
        if (done_c == 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", limit);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    vec_t tv[6];
    int   widx;
    int   dc;
    int   sc;
    int   d0;
    int   c0;
    int   p0;
    int   n;

    initial begin
        tv[0] = '{1'b0, 32'h0000_1234, 16'd1, 32'h0000_1220, 1'b0, 1'b0};
        tv[1] = '{1'b1, 32'h0000_0100, 16'd2, 32'h0000_0100, 1'b0, 1'b0};
        tv[2] = '{1'b0, 32'hFFFF_FFE0, 16'd2, 32'hFFFF_FFE0, 1'b0, 1'b1};
        tv[3] = '{1'b0, 32'h5555_5577, 16'd1, 32'h5555_5560, 1'b1, 1'b0};
        tv[4] = '{1'b1, 32'h8000_001F, 16'd1, 32'h8000_0000, 1'b1, 1'b1};
        tv[5] = '{1'b0, 32'h0000_0040, 16'd0, 32'h0000_0040, 1'b0, 1'b0};
        widx = 0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdat_valid", 64'(rdat_valid), 64'd0);
        chk("rst_wdat_ready", 64'(wdat_ready), 64'd1);
        chk("rst_wb_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst_wb_stb", 64'(wb_stb_o), 64'd0);
        chk("rst_wb_we", 64'(wb_we_o), 64'd0);
        chk("rst_wb_adr", 64'(wb_adr_o), 64'd0);
        chk("rst_wb_cti", 64'(wb_cti_o), 64'd0);
        chk("rst_wb_dat", wb_dat_o, 64'd0);
        chk("rst_wb_sel", 64'(wb_sel_o), 64'd0);
        chk("rst_nextadr_valid", 64'(wb_nextadr_valid), 64'd0);
        chk("rst_nextadr", 64'(wb_nextadr), 64'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            n = int'(tv[i].len);
            stall_mode = tv[i].stall;
            spur = tv[i].spur;
            if (tv[i].we) preload(widx, 4 * n);
            push_exp(tv[i].we, tv[i].base, n, widx);
            if (tv[i].we) widx += 4 * n;
            d0 = done_cnt;
            c0 = cyc_cnt;
            cmd_beat0 = beat_cnt;
            gap_en = 1'b1;
            issue(tv[i].we, tv[i].adr, tv[i].len);
            wait_done(400, dc, sc);
            if (n == 0) begin
                chk("zero_done_latency", 64'(dc), 64'd1);
                chk("zero_no_cyc", 64'(cyc_cnt - c0), 64'd0);
            end else begin
                chk("first_stb_latency", 64'(sc), 64'd2);
            end
            @(negedge sys_clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("idle_after", 64'(busy), 64'd0);
            repeat (8) @(negedge sys_clk);
            chk("beats_total", 64'(beat_cnt - cmd_beat0), 64'(4 * n));
            chk("beat_q_empty", 64'(beat_q.size()), 64'd0);
            chk("rdat_q_empty", 64'(rdat_q.size()), 64'd0);
            chk("done_count", 64'(done_cnt - d0), 64'd1);
            chk("wdat_ready_after", 64'(wdat_ready), 64'd1);
            gap_en = 1'b0;
            stall_mode = 1'b0;
            spur = 1'b0;
            @(posedge sys_clk);
            #1;
        end

        rdat_ready = 1'b0;
        push_exp(1'b0, 32'h0000_2000, 3, 0);
        d0 = done_cnt;
        cmd_beat0 = beat_cnt;
        issue(1'b0, 32'h0000_2000, 16'd3);
        repeat (40) @(negedge sys_clk);
        chk("bp_beats_held", 64'(beat_cnt - cmd_beat0), 64'd8);
        chk("bp_stb_low", 64'(wb_stb_o), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        chk("bp_rdat_valid", 64'(rdat_valid), 64'd1);
        chk("bp_no_done", 64'(done_cnt - d0), 64'd0);
        @(posedge sys_clk);
        #1;
        p0 = pop_cnt;
        rdat_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge sys_clk);
            #1;
            if (pop_cnt - p0 >= 4) break;
        end
        rdat_ready = 1'b0;
        chk("bp_pops", 64'(pop_cnt - p0), 64'd4);
        wait_done(200, dc, sc);
        chk("bp_third_burst", 64'(beat_cnt - cmd_beat0), 64'd12);
        @(posedge sys_clk);
        #1;
        rdat_ready = 1'b1;
        repeat (12) @(negedge sys_clk);
        chk("bp_rdat_q_empty", 64'(rdat_q.size()), 64'd0);
        chk("bp_beat_q_empty", 64'(beat_q.size()), 64'd0);
        chk("bp_done_count", 64'(done_cnt - d0), 64'd1);
        @(posedge sys_clk);
        #1;

        rdat_ready = 1'b0;
        push_exp(1'b0, 32'h0000_3000, 1, 0);
        d0 = done_cnt;
        cmd_beat0 = beat_cnt;
        issue(1'b0, 32'h0000_3000, 16'd1);
        for (int c = 0; c < 30; c++) begin
            @(posedge sys_clk);
            #1;
            if (beat_cnt - cmd_beat0 >= 2) break;
        end
        chk("rr_two_acks", 64'(beat_cnt - cmd_beat0), 64'd2);
        chk("rr_rdat_valid_pre", 64'(rdat_valid), 64'd1);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("rr_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rr_stb", 64'(wb_stb_o), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_rdat_valid", 64'(rdat_valid), 64'd0);
        chk("rr_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        beat_q.delete();
        rdat_q.delete();
        rdat_ready = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("rr_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rr_no_more_beats", 64'(beat_cnt - cmd_beat0), 64'd2);
        chk("rr_idle_cyc", 64'(wb_cyc_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
